ctrl_write_timer: RTL

Write-latency timer for the DDR4 controller: it converts each issued WR command into a precisely timed write-data window for the downstream write-data driver. It tracks up to `DEPTH` outstanding writes, counts WL = AL + CWL from command issue, and drives `wr_rdy` across preamble plus data. It also provides per-burst start/done strobes so seamless back-to-back bursts are distinguishable. It sits between the command scheduler (source of `wr_cmd`) and the write-data stage (consumer of `wr_rdy`).

---
 rtl/ddr_pkg.sv | 19 +
 rtl/ctrl_write_timer_if.sv | 33 +++
 rtl/wr_cmd_fifo.sv | 53 +++++
 rtl/ctrl_write_timer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// Shared DDR4 controller types used by the write-latency timer and its queue.
package ddr_pkg;

  localparam int WR_TS_W        = 8;
  localparam int WR_DATA_CYCLES = 4;

  typedef struct packed {
    logic [WR_TS_W-1:0] start;
    logic [1:0]         pre;
    logic [3:0]         bl;
  } wr_timer_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA
  } wr_timer_state_e;

endpackage

// File: rtl/ctrl_write_timer_if.sv
// Scheduler-to-timer bus: WR command with its per-command config, timed write window back.
interface ctrl_write_timer_if #(
  parameter int DEPTH = 4
);

  logic                     wr_cmd;
  logic [4:0]               cfg_cwl;
  logic [4:0]               cfg_al;
  logic [3:0]               cfg_bl;
  logic [1:0]               cfg_wr_pre;
  logic                     wr_rdy;
  logic                     wr_pre_en;
  logic                     wr_data_en;
  logic                     wr_start;
  logic                     wr_done;
  logic [1:0]               data_cyc;
  logic [$clog2(DEPTH):0]   pend_cnt;
  logic                     err_ovf;
  logic                     err_tccd;

  modport master (
    output wr_cmd, cfg_cwl, cfg_al, cfg_bl, cfg_wr_pre,
    input  wr_rdy, wr_pre_en, wr_data_en, wr_start, wr_done, data_cyc,
           pend_cnt, err_ovf, err_tccd
  );

  modport slave (
    input  wr_cmd, cfg_cwl, cfg_al, cfg_bl, cfg_wr_pre,
    output wr_rdy, wr_pre_en, wr_data_en, wr_start, wr_done, data_cyc,
           pend_cnt, err_ovf, err_tccd
  );

endinterface

// File: rtl/wr_cmd_fifo.sv
// Queue of outstanding write commands waiting for their launch time.
module wr_cmd_fifo
  import ddr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   CK_t,
  input  logic                   reset_n,
  input  logic                   push,
  input  wr_timer_entry_t        push_data,
  input  logic                   pop,
  output wr_timer_entry_t        head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  wr_timer_entry_t mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  // A pop on a full queue frees the slot for a push in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge CK_t) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_write_timer.sv
// Write-latency timer: turns each WR command into a timed preamble + data window
// for the write-data driver, with per-burst start/done strobes.
module ctrl_write_timer
  import ddr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TS_W  = WR_TS_W
) (
  input logic               CK_t,
  input logic               reset_n,
  ctrl_write_timer_if.slave bus
);

  localparam int         CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [1:0] LAST_DCYC = 2'(WR_DATA_CYCLES - 1);

  logic [TS_W-1:0]    ts;
  logic [TS_W-1:0]    ts_nx;
  wr_timer_entry_t    new_entry;
  wr_timer_entry_t    head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               launch;
  logic               ovf;

  wr_timer_state_e    state;
  wr_timer_state_e    state_nx;
  logic [1:0]         pre_left;
  logic [1:0]         pre_left_nx;
  logic [1:0]         dcyc;
  logic [1:0]         dcyc_nx;
  logic               seam_pend;
  logic               seam_nx;
  logic [WR_TS_W-1:0] cur_last;
  logic [WR_TS_W-1:0] last_nx;
  logic               start_nx;
  logic               tccd_nx;

  assign ts_nx = ts + TS_W'(1);

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) ts <= '0;
    else          ts <= ts_nx;
  end

  // Start time wraps with the timestamp; only equality is ever tested against it.
  assign new_entry = '{start: WR_TS_W'(ts + TS_W'(bus.cfg_al) + TS_W'(bus.cfg_cwl)),
                       pre:   bus.cfg_wr_pre,
                       bl:    bus.cfg_bl};

  // Decisions look one cycle ahead so the registered outputs appear exactly at ts == L.
  assign launch = !fifo_empty &&
                  (WR_TS_W'(ts_nx) == WR_TS_W'(head.start - WR_TS_W'(head.pre)));
  assign ovf    = bus.wr_cmd && fifo_full && !launch;

  wr_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CK_t      (CK_t),
    .reset_n   (reset_n),
    .push      (bus.wr_cmd),
    .push_data (new_entry),
    .pop       (launch),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.pend_cnt = fifo_count;

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pre_left  <= '0;
      dcyc      <= '0;
      seam_pend <= 1'b0;
      cur_last  <= '0;
    end else begin
      state     <= state_nx;
      pre_left  <= pre_left_nx;
      dcyc      <= dcyc_nx;
      seam_pend <= seam_nx;
      cur_last  <= last_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    pre_left_nx = pre_left;
    dcyc_nx     = dcyc;
    seam_nx     = seam_pend;
    last_nx     = cur_last;
    start_nx    = 1'b0;
    tccd_nx     = 1'b0;

    case (state)
      PRE: begin
        if (pre_left <= 2'd1) begin
          state_nx = DATA;
          dcyc_nx  = '0;
        end else begin
          pre_left_nx = pre_left - 2'd1;
        end
      end
      DATA: begin
        if (dcyc == LAST_DCYC) begin
          if (seam_pend) begin
            dcyc_nx  = '0;
            seam_nx  = 1'b0;
            last_nx  = cur_last + WR_TS_W'(WR_DATA_CYCLES);
            start_nx = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          dcyc_nx = dcyc + 2'd1;
        end
      end
      default: ;
    endcase

    // A launch only chains seamlessly when its data starts right after the current burst.
    if (launch) begin
      if (state_nx == IDLE) begin
        state_nx    = PRE;
        pre_left_nx = head.pre;
        last_nx     = head.start + WR_TS_W'(WR_DATA_CYCLES - 1);
        start_nx    = 1'b1;
      end else if (!seam_nx && (head.start == last_nx + WR_TS_W'(1))) begin
        seam_nx = 1'b1;
      end else begin
        tccd_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      bus.wr_rdy     <= 1'b0;
      bus.wr_pre_en  <= 1'b0;
      bus.wr_data_en <= 1'b0;
      bus.wr_start   <= 1'b0;
      bus.wr_done    <= 1'b0;
      bus.data_cyc   <= '0;
      bus.err_ovf    <= 1'b0;
      bus.err_tccd   <= 1'b0;
    end else begin
      bus.wr_rdy     <= (state_nx != IDLE);
      bus.wr_pre_en  <= (state_nx == PRE);
      bus.wr_data_en <= (state_nx == DATA);
      bus.wr_start   <= start_nx;
      bus.wr_done    <= (state_nx == DATA) && (dcyc_nx == LAST_DCYC);
      bus.data_cyc   <= (state_nx == DATA) ? dcyc_nx : 2'd0;
      bus.err_ovf    <= bus.err_ovf | ovf;
      bus.err_tccd   <= bus.err_tccd | tccd_nx;
    end
  end

endmodule
